// File: rtl/haze_pkg.sv
// Shared types and defaults for the haze-removal frame controllers,
// line buffers and window generator.
package haze_pkg;

  localparam int PIX_W     = 8;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DRAIN   = 2'd2,
    PUBLISH = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/alight_pos_counter.sv
// Raster col/row tracker for a 3x3 window stream: flags complete windows
// and the last pixel of the frame.
module alight_pos_counter import haze_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic start_i,
  input  logic adv_i,
  output logic win_o,
  output logic last_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // start consumes pixel (0,0) itself, so the next position is (1,0)
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start_i) begin
      col_d = CW'(1);
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign win_o  = (col_q >= CW'(2)) && (row_q >= RW'(2));
  assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/alight_frame_controller.sv
// Frame sequencer for the atmospheric-light estimators: gates est_enable,
// waits out the estimator pipeline and publishes held Ar/Ag/Ab.
//
// state   | meaning
// IDLE    | waiting for sof with a valid pixel
// SCAN    | accepting pixels of the current frame
// DRAIN   | last pixel taken, waiting EST_LATENCY cycles
// PUBLISH | capture estimator outputs; next frame may start here
module alight_frame_controller import haze_pkg::*; #(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int EST_LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] est_Ar,
  input  logic [PIX_W-1:0] est_Ag,
  input  logic [PIX_W-1:0] est_Ab,
  output logic             est_enable,
  output logic [PIX_W-1:0] Ar,
  output logic [PIX_W-1:0] Ag,
  output logic [PIX_W-1:0] Ab,
  output logic             a_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int DW = $clog2(EST_LATENCY + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(EST_LATENCY - 1);

  fsm_state_e state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;

  logic start_acc, adv_acc, win, last;
  logic est_enable_d, frame_err_d, publish;

  logic             est_enable_q, a_valid_q, frame_err_q;
  logic [PIX_W-1:0] ar_q, ag_q, ab_q;

  alight_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clock_i (clock),
    .reset_i (reset),
    .clear_i (sof),
    .start_i (start_acc),
    .adv_i   (adv_acc),
    .win_o   (win),
    .last_o  (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // sof always restarts: it aborts SCAN/DRAIN and chains directly after PUBLISH
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, PUBLISH: state_d = (sof && pix_valid) ? SCAN : IDLE;
      SCAN: begin
        if (sof)                    state_d = pix_valid ? SCAN : IDLE;
        else if (pix_valid && last) state_d = DRAIN;
      end
      DRAIN: begin
        if (sof)                          state_d = pix_valid ? SCAN : IDLE;
        else if (drain_q == DRAIN_LAST)   state_d = PUBLISH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_acc    = sof && pix_valid;
    adv_acc      = (state_q == SCAN) && pix_valid && !sof;
    est_enable_d = adv_acc && win;
    frame_err_d  = sof && ((state_q == SCAN) || (state_q == DRAIN));
    publish      = (state_q == PUBLISH);
    drain_d      = (state_q == DRAIN) ? drain_q + DW'(1) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      est_enable_q <= 1'b0;
      a_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      ar_q         <= '0;
      ag_q         <= '0;
      ab_q         <= '0;
    end else begin
      est_enable_q <= est_enable_d;
      a_valid_q    <= publish;
      frame_err_q  <= frame_err_d;
      if (publish) begin
        ar_q <= est_Ar;
        ag_q <= est_Ag;
        ab_q <= est_Ab;
      end
    end
  end

  assign est_enable = est_enable_q;
  assign a_valid    = a_valid_q;
  assign frame_err  = frame_err_q;
  assign Ar         = ar_q;
  assign Ag         = ag_q;
  assign Ab         = ab_q;
  assign busy       = (state_q != IDLE);

endmodule
